time_set_ctrl: RTL and testbench

//   Button-driven time-setting sequencer for the digital clock timekeeper (normal).

---
 rtl/time_set_ctrl_if.sv | 26 ++
 rtl/time_set_ctrl.sv | 163 ++++++++++++++++
 tb/tb_time_set_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/time_set_ctrl_if.sv
// Front-panel / timekeeper signal bundle for the time-setting sequencer.
// The master side drives the buttons and the running time, and the slave side
// (the sequencer) drives the load strobe, the shadow time and the display hints.
interface time_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic       set_time_flag;
    logic [4:0] set_hours;
    logic [5:0] set_minutes;
    logic       edit_active;
    logic [1:0] edit_field;
    logic       blink;

    modport master (
        output btn_mode, btn_inc, btn_dec, cur_hours, cur_minutes,
        input  set_time_flag, set_hours, set_minutes, edit_active, edit_field, blink
    );

    modport slave (
        input  btn_mode, btn_inc, btn_dec, cur_hours, cur_minutes,
        output set_time_flag, set_hours, set_minutes, edit_active, edit_field, blink
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Button-driven time-setting sequencer. Snapshots the running time into shadow
// registers, lets the user edit hours then minutes, and emits a one-cycle load
// strobe carrying the edited time. An idle edit is abandoned without a strobe.
module time_set_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 30,
    parameter int unsigned BLINK_CYC   = 1
) (
    input  logic           clk,
    input  logic           rst,
    time_set_ctrl_if.slave bus_io
);

    // Counters only ever hold 0..N-1, so $clog2(N) bits suffice (min 1).
    localparam int unsigned ToW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned BlW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYC - 1);
    localparam logic [BlW-1:0] BlLast = BlW'(BLINK_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StEditH,
        StEditM,
        StCommit
    } state_e;

    state_e         state_q, state_d;
    logic           btn_mode_q, btn_inc_q, btn_dec_q;
    logic [4:0]     shadow_h_q, shadow_h_d;
    logic [5:0]     shadow_m_q, shadow_m_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic [BlW-1:0] bl_cnt_q, bl_cnt_d;
    logic           blink_q, blink_d;

    logic       press_mode, press_inc, press_dec;
    logic       any_press, inc_only, dec_only, timed_out;
    logic       next_is_edit;
    logic [4:0] cap_h, h_inc, h_dec;
    logic [5:0] cap_m, m_inc, m_dec;

    // Rising-edge detection against the registered button copies.
    always_comb begin
        press_mode = bus_io.btn_mode & ~btn_mode_q;
        press_inc  = bus_io.btn_inc & ~btn_inc_q;
        press_dec  = bus_io.btn_dec & ~btn_dec_q;
        any_press  = press_mode | press_inc | press_dec;
        // inc together with dec cancels out
        inc_only   = press_inc & ~press_dec;
        dec_only   = press_dec & ~press_inc;
        timed_out  = ~any_press & (to_cnt_q == ToLast);
    end

    // Clamped capture values and compare-based wrap arithmetic.
    always_comb begin
        cap_h = (bus_io.cur_hours > 5'd23) ? 5'd0 : bus_io.cur_hours;
        cap_m = (bus_io.cur_minutes > 6'd59) ? 6'd0 : bus_io.cur_minutes;
        h_inc = (shadow_h_q == 5'd23) ? 5'd0 : shadow_h_q + 5'd1;
        h_dec = (shadow_h_q == 5'd0) ? 5'd23 : shadow_h_q - 5'd1;
        m_inc = (shadow_m_q == 6'd59) ? 6'd0 : shadow_m_q + 6'd1;
        m_dec = (shadow_m_q == 6'd0) ? 6'd59 : shadow_m_q - 6'd1;
    end

    // Next-state, shadow edits, timeout and blink bookkeeping.
    always_comb begin
        state_d    = state_q;
        shadow_h_d = shadow_h_q;
        shadow_m_d = shadow_m_q;
        to_cnt_d   = '0;
        bl_cnt_d   = '0;
        blink_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (press_mode) begin
                    shadow_h_d = cap_h;
                    shadow_m_d = cap_m;
                    state_d    = StEditH;
                end
            end
            StEditH: begin
                if (press_mode) begin
                    state_d = StEditM;
                end else if (timed_out) begin
                    state_d = StIdle;
                end else if (inc_only) begin
                    shadow_h_d = h_inc;
                end else if (dec_only) begin
                    shadow_h_d = h_dec;
                end
            end
            StEditM: begin
                if (press_mode) begin
                    state_d = StCommit;
                end else if (timed_out) begin
                    state_d = StIdle;
                end else if (inc_only) begin
                    shadow_m_d = m_inc;
                end else if (dec_only) begin
                    shadow_m_d = m_dec;
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        next_is_edit = (state_d == StEditH) || (state_d == StEditM);

        if (next_is_edit) begin
            if (state_d != state_q) begin
                // Fresh field: blink restarts lit, idle count restarts.
                blink_d = 1'b1;
            end else begin
                to_cnt_d = any_press ? '0 : to_cnt_q + 1'b1;
                if (bl_cnt_q == BlLast) begin
                    blink_d = ~blink_q;
                end else begin
                    blink_d  = blink_q;
                    bl_cnt_d = bl_cnt_q + 1'b1;
                end
            end
        end
    end

    // State and datapath registers; reset abandons any edit without a strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            btn_mode_q <= 1'b0;
            btn_inc_q  <= 1'b0;
            btn_dec_q  <= 1'b0;
            shadow_h_q <= '0;
            shadow_m_q <= '0;
            to_cnt_q   <= '0;
            bl_cnt_q   <= '0;
            blink_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_mode_q <= bus_io.btn_mode;
            btn_inc_q  <= bus_io.btn_inc;
            btn_dec_q  <= bus_io.btn_dec;
            shadow_h_q <= shadow_h_d;
            shadow_m_q <= shadow_m_d;
            to_cnt_q   <= to_cnt_d;
            bl_cnt_q   <= bl_cnt_d;
            blink_q    <= blink_d;
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        bus_io.set_time_flag = (state_q == StCommit);
        bus_io.edit_active   = (state_q == StEditH) || (state_q == StEditM);
        bus_io.edit_field    = (state_q == StEditH) ? 2'b01 :
                               (state_q == StEditM) ? 2'b10 : 2'b00;
        bus_io.set_hours     = shadow_h_q;
        bus_io.set_minutes   = shadow_m_q;
        bus_io.blink         = blink_q;
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random button traffic, all
// checked every cycle against a phase/arithmetic model of the sequencer.
module tb_time_set_ctrl;
    localparam int TO = 30;
    localparam int BC = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    time_set_ctrl_if bus();

    time_set_ctrl #(
        .TIMEOUT_CYC(TO),
        .BLINK_CYC  (BC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 editing hours, 2 editing minutes, 3 committing
    int m_phase = 0, m_h = 0, m_m = 0, m_quiet = 0, m_age = 0;
    bit pv_m = 0, pv_i = 0, pv_d = 0;
    bit pm, pi, pd, anyp;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_h = 0; m_m = 0; m_quiet = 0; m_age = 0;
            pv_m = 0; pv_i = 0; pv_d = 0;
        end else begin
            pm = bus.btn_mode && !pv_m;
            pi = bus.btn_inc && !pv_i;
            pd = bus.btn_dec && !pv_d;
            pv_m = bus.btn_mode; pv_i = bus.btn_inc; pv_d = bus.btn_dec;
            anyp = pm || pi || pd;
            case (m_phase)
                0: if (pm) begin
                    m_h = (bus.cur_hours > 23) ? 0 : int'(bus.cur_hours);
                    m_m = (bus.cur_minutes > 59) ? 0 : int'(bus.cur_minutes);
                    m_phase = 1; m_age = 0; m_quiet = 0;
                end
                1, 2: if (pm) begin
                    m_phase = m_phase + 1; m_age = 0; m_quiet = 0;
                end else begin
                    m_quiet = anyp ? 0 : m_quiet + 1;
                    if (m_quiet >= TO) begin
                        m_phase = 0;
                    end else begin
                        if (pi && !pd) begin
                            if (m_phase == 1) m_h = (m_h + 1) % 24;
                            else              m_m = (m_m + 1) % 60;
                        end else if (pd && !pi) begin
                            if (m_phase == 1) m_h = (m_h + 23) % 24;
                            else              m_m = (m_m + 59) % 60;
                        end
                        m_age++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    int dut_strobes = 0, mdl_strobes = 0;
    int dut_last_h = -1, dut_last_m = -1, mdl_last_h = -1, mdl_last_m = -1;
    int e_flag, e_act, e_field, e_blink;

    always @(negedge clk) begin
        e_flag  = (m_phase == 3);
        e_act   = (m_phase == 1 || m_phase == 2);
        e_field = (m_phase == 1) ? 1 : (m_phase == 2) ? 2 : 0;
        e_blink = e_act && (((m_age / BC) % 2) == 0);
        check("set_time_flag", int'(bus.set_time_flag), e_flag);
        check("edit_active", int'(bus.edit_active), e_act);
        check("edit_field", int'(bus.edit_field), e_field);
        check("blink", int'(bus.blink), e_blink);
        if (e_flag) begin
            check("set_hours", int'(bus.set_hours), m_h);
            check("set_minutes", int'(bus.set_minutes), m_m);
            mdl_strobes++; mdl_last_h = m_h; mdl_last_m = m_m;
        end
        if (bus.set_time_flag) begin
            dut_strobes++;
            dut_last_h = int'(bus.set_hours); dut_last_m = int'(bus.set_minutes);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(bit m, bit i, bit d);
        bus.btn_mode = m; bus.btn_inc = i; bus.btn_dec = d;
        tick(1);
        bus.btn_mode = 0; bus.btn_inc = 0; bus.btn_dec = 0;
        tick(1);
    endtask

    task automatic set_cur(int h, int m);
        bus.cur_hours = 5'(h);
        bus.cur_minutes = 6'(m);
    endtask

    task automatic expect_strobe(string name, int s0, int h, int m);
        check({name, "_count"}, dut_strobes, s0 + 1);
        check({name, "_hours"}, dut_last_h, h);
        check({name, "_minutes"}, dut_last_m, m);
        check({name, "_model_hours"}, mdl_last_h, h);
        check({name, "_model_minutes"}, mdl_last_m, m);
        check({name, "_idle_after"}, int'(bus.edit_active), 0);
    endtask

    int s0;

    initial begin
        bus.btn_mode = 0; bus.btn_inc = 0; bus.btn_dec = 0;
        set_cur(0, 0);

        // Reset held for three cycles
        tick(3);
        check("rst_flag", int'(bus.set_time_flag), 0);
        check("rst_active", int'(bus.edit_active), 0);
        check("rst_field", int'(bus.edit_field), 0);
        check("rst_blink", int'(bus.blink), 0);
        check("rst_hours", int'(bus.set_hours), 0);
        check("rst_minutes", int'(bus.set_minutes), 0);
        rst = 1'b1;
        tick(2);

        // Full set 10:30 -> 12:29
        set_cur(10, 30); s0 = dut_strobes;
        press(1, 0, 0);
        check("full_field_h", int'(bus.edit_field), 1);
        press(0, 1, 0); press(0, 1, 0);
        press(1, 0, 0);
        check("full_field_m", int'(bus.edit_field), 2);
        press(0, 0, 1);
        press(1, 0, 0);
        expect_strobe("full", s0, 12, 29);

        // Wrap upward 23:59 -> 0:00
        set_cur(23, 59); s0 = dut_strobes;
        press(1, 0, 0); press(0, 1, 0); press(1, 0, 0); press(0, 1, 0); press(1, 0, 0);
        expect_strobe("wrap_up", s0, 0, 0);

        // Wrap downward 0:00 -> 23:59
        set_cur(0, 0); s0 = dut_strobes;
        press(1, 0, 0); press(0, 0, 1); press(1, 0, 0); press(0, 0, 1); press(1, 0, 0);
        expect_strobe("wrap_dn", s0, 23, 59);

        // Out-of-range capture clamps to zero
        set_cur(31, 63); s0 = dut_strobes;
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        expect_strobe("clamp", s0, 0, 0);

        // Timeout: a press with the idle count at TO-2 restarts it
        set_cur(7, 45); s0 = dut_strobes;
        press(1, 0, 0);
        tick(TO - 3);
        press(0, 1, 0);
        tick(TO - 2);
        check("timeout_still_active", int'(bus.edit_active), 1);
        tick(1);
        check("timeout_expired", int'(bus.edit_active), 0);
        tick(5);
        check("timeout_no_strobe", dut_strobes, s0);

        // Simultaneous presses and held button
        set_cur(5, 17); s0 = dut_strobes;
        press(1, 0, 0);
        press(0, 1, 1);
        press(1, 1, 0);
        check("simul_field_m", int'(bus.edit_field), 2);
        bus.btn_inc = 1; tick(10); bus.btn_inc = 0; tick(1);
        press(1, 0, 0);
        expect_strobe("simul", s0, 5, 18);

        // Async reset in the middle of a minutes edit
        set_cur(8, 8); s0 = dut_strobes;
        press(1, 0, 0); press(1, 0, 0);
        check("areset_pre_field", int'(bus.edit_field), 2);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("areset_active", int'(bus.edit_active), 0);
        check("areset_field", int'(bus.edit_field), 0);
        check("areset_blink", int'(bus.blink), 0);
        check("areset_flag", int'(bus.set_time_flag), 0);
        check("areset_hours", int'(bus.set_hours), 0);
        tick(2);
        rst = 1'b1;
        tick(40);
        check("areset_no_strobe", dut_strobes, s0);

        // Random traffic with periodic quiet stretches to exercise timeouts
        for (int k = 0; k < 3000; k++) begin
            if ((k % 250) < 40) begin
                bus.btn_mode = 0; bus.btn_inc = 0; bus.btn_dec = 0;
            end else begin
                bus.btn_mode = ($urandom_range(0, 5) == 0);
                bus.btn_inc  = ($urandom_range(0, 2) == 0);
                bus.btn_dec  = ($urandom_range(0, 2) == 0);
            end
            set_cur(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)));
            tick(1);
        end
        bus.btn_mode = 0; bus.btn_inc = 0; bus.btn_dec = 0;
        tick(3);
        check("strobe_total", dut_strobes, mdl_strobes);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
